// File: rtl/cpu_pkg.sv
// Shared CPU core types: default register-file geometry, word/address types
// and the active level of the register-file write enable.
package cpu_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

  typedef logic [DEFAULT_DATA_W-1:0] word_t;
  typedef logic [DEFAULT_ADDR_W-1:0] gpr_addr_t;

  localparam logic WE_ACTIVE = 1'b0;

  // Non-power-of-2 register counts leave part of the address space unpopulated.
  function automatic logic addrInRange(input int unsigned addr, input int unsigned numRegs);
    return addr < numRegs;
  endfunction

endpackage

// File: rtl/modport_regfile_rdport.sv
// One asynchronous read port: address range check, register select and
// same-cycle forwarding of the write in flight.
module modport_regfile_rdport
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]               rd_addr_i,
  input  logic                            wr_fire_i,
  input  logic [ADDR_W-1:0]               wr_addr_i,
  input  logic [DATA_W-1:0]               wr_data_i,
  output logic [DATA_W-1:0]               rd_data_o
);

  logic              rdInRange;
  logic              bypassHit;
  logic [DATA_W-1:0] storedData;

  assign rdInRange = addrInRange(32'(rd_addr_i), NUM_REGS);

  // wr_fire_i already excludes out-of-range and discarded writes, so an
  // address match alone is enough to forward.
  assign bypassHit = wr_fire_i && (rd_addr_i == wr_addr_i);

  always_comb begin
    storedData = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_addr_i) == i) begin
        storedData = regs_i[i];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (bypassHit) begin
      rd_data_o = wr_data_i;
    end else if (rdInRange) begin
      rd_data_o = storedData;
    end
  end

endmodule

// File: rtl/modport_regfile.sv
// CPU general-purpose register file: two combinational read ports with
// write forwarding, one synchronous write port (active-low enable).
// Define MODPORT_REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module modport_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_0,
  output logic [DATA_W-1:0] rd_data_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_we_n
);

`ifdef MODPORT_REGFILE_ZERO_REG_EN
  localparam int FIRST_REG = 1;
`else
  localparam int FIRST_REG = 0;
`endif

  logic [DATA_W-1:0]               regs_q [FIRST_REG:NUM_REGS-1];
  logic [DATA_W-1:0]               regs_d [FIRST_REG:NUM_REGS-1];
  logic [NUM_REGS-1:0][DATA_W-1:0] regView;
  logic                            weAsserted;
  logic                            wrFire;

  // An X/Z enable never satisfies the if, so it behaves as deasserted.
  always_comb begin
    weAsserted = 1'b0;
    if (wr_we_n == WE_ACTIVE) begin
      weAsserted = 1'b1;
    end
  end

  // A write lands (and forwards) only outside reset, in range, and not to a
  // hardwired register.
  always_comb begin
    wrFire = 1'b0;
    if (!rst && weAsserted && addrInRange(32'(wr_addr), NUM_REGS)
        && (32'(wr_addr) >= FIRST_REG)) begin
      wrFire = 1'b1;
    end
  end

  always_comb begin
    for (int i = FIRST_REG; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wrFire && (32'(wr_addr) == i)) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = FIRST_REG; i < NUM_REGS; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    regView = '0;
    for (int i = FIRST_REG; i < NUM_REGS; i++) begin
      regView[i] = regs_q[i];
    end
  end

  modport_regfile_rdport #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rdport0 (
    .regs_i    (regView),
    .rd_addr_i (rd_addr_0),
    .wr_fire_i (wrFire),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_data_o (rd_data_0)
  );

  modport_regfile_rdport #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rdport1 (
    .regs_i    (regView),
    .rd_addr_i (rd_addr_1),
    .wr_fire_i (wrFire),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_data_o (rd_data_1)
  );

endmodule

// File: tb/tb_modport_regfile.sv
// Directed self-checking bench for modport_regfile: reset, write/read,
// forwarding, enable polarity, mid-run reset and register-0 behaviour.
module tb_modport_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  rdAddr0;
  logic [31:0] rdData0;
  logic [4:0]  rdAddr1;
  logic [31:0] rdData1;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic        wrWeN;

  int checks;
  int failures;

  modport_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_0 (rdAddr0),
    .rd_data_0 (rdData0),
    .rd_addr_1 (rdAddr1),
    .rd_data_1 (rdData1),
    .wr_addr   (wrAddr),
    .wr_data   (wrData),
    .wr_we_n   (wrWeN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all inputs, then let the combinational read path settle.
  task automatic applyStimulus(input logic r, input logic weN, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] ra0,
                               input logic [4:0] ra1);
    rst     = r;
    wrWeN   = weN;
    wrAddr  = wa;
    wrData  = wd;
    rdAddr0 = ra0;
    rdAddr1 = ra1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r0Expect;
    checks   = 0;
    failures = 0;

    // Reset, then every register reads zero on both ports
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      checkOutput($sformatf("reset_rd0_r%0d", i), rdData0, 32'h0);
      checkOutput($sformatf("reset_rd1_r%0d", 31 - i), rdData1, 32'h0);
    end

    // Reset beats a concurrent write and suppresses forwarding
    applyStimulus(1'b1, 1'b0, 5'd5, 32'h0000_DEAD, 5'd5, 5'd5);
    checkOutput("rst_nobypass_r5", rdData0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h0000_DEAD, 5'd5, 5'd5);
    checkOutput("rst_write_dropped_r5", rdData0, 32'h0);

    // Plain write then stored read
    applyStimulus(1'b0, 1'b0, 5'd3, 32'h1234_5678, 5'd0, 5'd4);
    checkOutput("wr3_other_port_r4", rdData1, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd4);
    checkOutput("rd_r3", rdData0, 32'h1234_5678);
    checkOutput("rd_r4", rdData1, 32'h0);

    // Forwarding: both ports hit the register being written
    applyStimulus(1'b0, 1'b0, 5'd7, 32'h0000_0001, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hCAFE_BABE, 5'd7, 5'd7);
    checkOutput("r7_before_bypass", rdData0, 32'h0000_0001);
    applyStimulus(1'b0, 1'b0, 5'd7, 32'hCAFE_BABE, 5'd7, 5'd7);
    checkOutput("bypass_rd0_r7", rdData0, 32'hCAFE_BABE);
    checkOutput("bypass_rd1_r7", rdData1, 32'hCAFE_BABE);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h0, 5'd7, 5'd3);
    checkOutput("stored_rd0_r7", rdData0, 32'hCAFE_BABE);
    checkOutput("stored_rd1_r3", rdData1, 32'h1234_5678);

    // Enable is active low: we_n=1 must neither write nor forward
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 5'd9, 32'hFFFF_FFFF, 5'd9, 5'd9);
      checkOutput($sformatf("we_n_high_nobypass_c%0d", c), rdData0, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h0, 5'd9, 5'd9);
    checkOutput("we_n_high_r9_unwritten", rdData1, 32'h0);

    // Fill r1..r31 with their index, spot-check, then reset mid-run
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'(i), 32'(i), 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h0, 5'd31, 5'd17);
    checkOutput("fill_r31", rdData0, 32'd31);
    checkOutput("fill_r17", rdData1, 32'd17);
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h0, 5'd31, 5'd17);
    tick();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd0, 32'h0, 5'(i), 5'(i));
      checkOutput($sformatf("midrst_rd0_r%0d", i), rdData0, 32'h0);
      checkOutput($sformatf("midrst_rd1_r%0d", i), rdData1, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 5'd12, 32'h0000_0055, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h0, 5'd12, 5'd13);
    checkOutput("post_rst_write_r12", rdData0, 32'h0000_0055);
    checkOutput("post_rst_r13_clear", rdData1, 32'h0);

    // Register 0: hardwired zero in the zero-register build, ordinary otherwise
`ifdef MODPORT_REGFILE_ZERO_REG_EN
    r0Expect = 32'h0;
`else
    r0Expect = 32'h0000_AAAA;
`endif
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0000_AAAA, 5'd0, 5'd0);
    checkOutput("r0_same_cycle", rdData0, r0Expect);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h0, 5'd0, 5'd12);
    checkOutput("r0_after_edge", rdData0, r0Expect);
    checkOutput("r12_untouched", rdData1, 32'h0000_0055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
